// File: rtl/serializer_pkg.sv
// Shared types and line levels for the parallel-in/serial-out transmitter.
package serializer_pkg;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/bit_tick_counter.sv
// Bit-period timer: counts 0..DIV-1 and flags the last cycle of each serial bit.
module bit_tick_counter #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick,
  output logic tick_next
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

  // tick_next lets the parent register a pulse that lines up with tick.
  generate
    if (DIV == 1) begin : g_div1
      assign tick_next = 1'b1;
    end else begin : g_divn
      assign tick_next = !clear && !tick && (cnt == CW'(DIV - 2));
    end
  endgenerate

endmodule

// File: rtl/dff_piso_serializer.sv
// Framed PISO transmitter: start bit, WIDTH data bits, stop bit, each DIV cycles.
module dff_piso_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV       = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             sout_d, busy_d, done_d, ready_d;
  logic             tick, tick_next;

  bit_tick_counter #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state_q == S_IDLE),
    .tick      (tick),
    .tick_next (tick_next)
  );

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    case (state_q)
      S_IDLE: begin
        if (din_valid && din_ready) begin
          state_d  = S_START;
          sr_d     = din;
          bitcnt_d = '0;
        end
      end
      S_START: begin
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          if (bitcnt_q == LAST_BIT) begin
            state_d = S_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
            sr_d     = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
          end
        end
      end
      S_STOP: begin
        if (tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pin outputs are computed from next state so they can be driven straight from flops.
    case (state_d)
      S_START: sout_d = START_BIT;
      S_DATA:  sout_d = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
      default: sout_d = LINE_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_STOP) && tick_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      bitcnt_q  <= '0;
      sout      <= LINE_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      din_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bitcnt_q  <= bitcnt_d;
      sout      <= sout_d;
      busy      <= busy_d;
      done      <= done_d;
      din_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_dff_piso_serializer.sv
// Directed scoreboard bench for dff_piso_serializer in three parameterisations.
module tb_dff_piso_serializer;

  typedef struct packed {
    logic sout;
    logic busy;
    logic ready;
    logic done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din_a = '0, din_b = '0;
  logic [3:0] din_c = '0;
  logic       v_a = 1'b0, v_b = 1'b0, v_c = 1'b0;
  logic       rdy_a, rdy_b, rdy_c;
  logic       sout_a, sout_b, sout_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       o_sout, o_busy, o_ready, o_done;
  int         cur = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  dff_piso_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(v_a), .din_ready(rdy_a),
    .sout(sout_a), .busy(busy_a), .done(done_a));

  dff_piso_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(v_b), .din_ready(rdy_b),
    .sout(sout_b), .busy(busy_b), .done(done_b));

  dff_piso_serializer #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .din(din_c), .din_valid(v_c), .din_ready(rdy_c),
    .sout(sout_c), .busy(busy_c), .done(done_c));

  always_comb begin
    case (cur)
      1:       begin o_sout = sout_b; o_busy = busy_b; o_ready = rdy_b; o_done = done_b; end
      2:       begin o_sout = sout_c; o_busy = busy_c; o_ready = rdy_c; o_done = done_c; end
      default: begin o_sout = sout_a; o_busy = busy_a; o_ready = rdy_a; o_done = done_a; end
    endcase
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic b, input logic r, input logic d);
    exp_t e;
    e.sout = s; e.busy = b; e.ready = r; e.done = d;
    return e;
  endfunction

  task automatic push_frame(input int sel, input logic [7:0] word);
    int  w, d;
    bit  m;
    logic b;
    case (sel)
      1:       begin w = 8; d = 4; m = 1'b0; end
      2:       begin w = 4; d = 1; m = 1'b1; end
      default: begin w = 8; d = 4; m = 1'b1; end
    endcase
    for (int k = 0; k < d; k++) sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < w; i++) begin
      b = m ? word[w-1-i] : word[i];
      for (int k = 0; k < d; k++) sb.push_back(mk(b, 1'b1, 1'b0, 1'b0));
    end
    for (int k = 0; k < d; k++) sb.push_back(mk(1'b1, 1'b1, 1'b0, k == d - 1));
  endtask

  task automatic push_idle();
    sb.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0));
  endtask

  // Called at a negedge; returns #1 after the accepting posedge.
  task automatic accept(input int sel, input logic [7:0] word, input bit hold,
                        input logic [7:0] after);
    cur = sel;
    case (sel)
      1:       begin din_b = word; v_b = 1'b1; end
      2:       begin din_c = word[3:0]; v_c = 1'b1; end
      default: begin din_a = word; v_a = 1'b1; end
    endcase
    #1 chk("ready_before_accept", o_ready, 1'b1);
    @(posedge clk);
    #1;
    case (sel)
      1:       begin din_b = after; if (!hold) v_b = 1'b0; end
      2:       begin din_c = after[3:0]; if (!hold) v_c = 1'b0; end
      default: begin din_a = after; if (!hold) v_a = 1'b0; end
    endcase
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      chk("sout", o_sout, e.sout);
      chk("busy", o_busy, e.busy);
      chk("din_ready", o_ready, e.ready);
      chk("done", o_done, e.done);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with valid asserted: nothing may be accepted.
    cur   = 0;
    din_a = 8'h5A;
    v_a   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_sout", o_sout, 1'b1);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_ready", o_ready, 1'b0);
      chk("rst_done", o_done, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", o_busy, 1'b0);
    chk("post_rst_ready", o_ready, 1'b1);
    chk("post_rst_sout", o_sout, 1'b1);
    v_a = 1'b0;

    // MSB-first 8'hA5, din scrambled after acceptance.
    push_frame(0, 8'hA5);
    push_idle();
    accept(0, 8'hA5, 1'b0, 8'h5A);
    drain();

    // LSB-first: 8'hA5 and 8'h01.
    push_frame(1, 8'hA5);
    push_idle();
    accept(1, 8'hA5, 1'b0, 8'h00);
    drain();
    push_frame(1, 8'h01);
    push_idle();
    accept(1, 8'h01, 1'b0, 8'hFF);
    drain();

    // Valid held high: second word accepted 41 cycles after the first.
    push_frame(0, 8'h3C);
    push_idle();
    push_frame(0, 8'hC3);
    push_idle();
    accept(0, 8'h3C, 1'b1, 8'hC3);
    drain();
    v_a = 1'b0;

    // Asynchronous reset in cycle 15 of a frame.
    accept(0, 8'h00, 1'b0, 8'h00);
    repeat (14) @(negedge clk);
    chk("pre_abort_busy", o_busy, 1'b1);
    chk("pre_abort_sout", o_sout, 1'b0);
    @(posedge clk);
    #1;
    chk("cycle15_sout", o_sout, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_sout", o_sout, 1'b1);
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_ready", o_ready, 1'b0);
    chk("abort_done", o_done, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold_done", o_done, 1'b0);
      chk("abort_hold_sout", o_sout, 1'b1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_abort_ready", o_ready, 1'b1);
    chk("post_abort_busy", o_busy, 1'b0);
    push_frame(0, 8'hFF);
    push_idle();
    accept(0, 8'hFF, 1'b0, 8'h00);
    drain();

    // DIV=1, WIDTH=4: six-cycle frame.
    push_frame(2, 8'h09);
    push_idle();
    accept(2, 8'h09, 1'b0, 8'h06);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
